// File: rtl/alu_pkg.sv
// Shared definitions for the scalar ALU interface and the lane sequencer.
package alu_pkg;

  // ALU operation codes; 3'b000 is reserved and forwarded unchanged.
  typedef enum logic [2:0] {
    XOR = 3'd1,
    ADD = 3'd2,
    SUB = 3'd3,
    MUL = 3'd4,
    SHR = 3'd5,
    SHL = 3'd6,
    INC = 3'd7
  } alu_op_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_lane_sequencer.sv
// Vector-to-scalar sequencer: accepts one vector instruction, feeds the
// external combinational ALU one lane per cycle, collects results and flags,
// and presents the assembled vector to the consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result/mask outputs stay stable while out_valid is held by out_ready=0.
module alu_lane_sequencer
  import alu_pkg::*;
#(
  parameter int dataSize = 8,
  parameter int LANES    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [LANES*dataSize-1:0] in_a,
  input  logic [LANES*dataSize-1:0] in_b,
  output logic [2:0]                alu_op,
  output logic [dataSize-1:0]       alu_a,
  output logic [dataSize-1:0]       alu_b,
  input  logic [dataSize-1:0]       alu_result,
  input  logic                      alu_neg,
  input  logic                      alu_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*dataSize-1:0] out_result,
  output logic [LANES-1:0]          out_neg_mask,
  output logic [LANES-1:0]          out_zero_mask,
  output logic                      busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW = LANES * dataSize;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  seq_state_t      state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [2:0]      op_q, op_d;
  logic [VW-1:0]   a_q, a_d;
  logic [VW-1:0]   b_q, b_d;
  logic [VW-1:0]   res_q, res_d;
  logic [LANES-1:0] neg_q, neg_d;
  logic [LANES-1:0] zero_q, zero_d;

  // Bit offset of the lane currently being issued.
  int lane_base;
  assign lane_base = int'(lane_q) * dataSize;

  // Next-state, datapath capture and handshake/ALU outputs.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_op    = 3'd0;
    alu_a     = '0;
    alu_b     = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          lane_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        alu_op = op_q;
        alu_a  = a_q[lane_base +: dataSize];
        alu_b  = b_q[lane_base +: dataSize];
        res_d[lane_base +: dataSize] = alu_result;
        neg_d[lane_q]  = alu_neg;
        zero_d[lane_q] = alu_zero;
        if (lane_q == LAST_LANE) begin
          lane_d  = '0;
          state_d = DONE;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Instruction and result registers; results persist after DONE until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 3'd0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      neg_q  <= '0;
      zero_q <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
    end
  end

  assign out_result    = res_q;
  assign out_neg_mask  = neg_q;
  assign out_zero_mask = zero_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Bench for alu_lane_sequencer with a behavioural 8-bit ALU attached and a
// lane-by-lane arithmetic reference model feeding an expected-result queue.
module tb_alu_lane_sequencer;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int VW = DW * NL;
  localparam int W  = VW + 2 * NL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT + ALU ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_neg, alu_zero;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_result;
  logic [NL-1:0] out_neg_mask, out_zero_mask;
  logic          busy;

  alu_lane_sequencer #(.dataSize(DW), .LANES(NL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_neg_mask(out_neg_mask), .out_zero_mask(out_zero_mask), .busy(busy)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd1: alu_result = alu_a ^ alu_b;
      3'd2: alu_result = alu_a + alu_b;
      3'd3: alu_result = alu_a - alu_b;
      3'd4: alu_result = alu_a * alu_b;
      3'd5: alu_result = alu_a >> alu_b;
      3'd6: alu_result = alu_a << alu_b;
      3'd7: alu_result = alu_a + 8'd1;
      default: alu_result = '0;
    endcase
  end
  assign alu_neg  = alu_result[DW-1];
  assign alu_zero = (alu_result == '0);

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: per-lane result using integer arithmetic mod 256.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [VW-1:0] a,
                                             input logic [VW-1:0] b);
    logic [VW-1:0] res;
    logic [NL-1:0] neg, zer;
    int x, y, r;
    res = '0; neg = '0; zer = '0;
    for (int i = 0; i < NL; i++) begin
      x = int'(a[i*DW +: DW]);
      y = int'(b[i*DW +: DW]);
      case (op)
        3'd1: r = x ^ y;
        3'd2: r = (x + y) % 256;
        3'd3: r = (x - y + 256) % 256;
        3'd4: r = (x * y) % 256;
        3'd5: r = (y >= 8) ? 0 : x / (1 << y);
        3'd6: r = (y >= 8) ? 0 : (x * (1 << y)) % 256;
        3'd7: r = (x + 1) % 256;
        default: r = 0;
      endcase
      res[i*DW +: DW] = DW'(r);
      neg[i] = (r >= 128);
      zer[i] = (r == 0);
    end
    return {res, neg, zer};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int acc_cnt = 0;
  int out_cnt = 0;

  // Observe both handshakes just after inputs settle for the coming edge.
  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #1;
    if (rst_n && in_valid && in_ready) acc_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_result", 64'(out_result), 64'(e[W-1 -: VW]));
        check("out_neg", 64'(out_neg_mask), 64'(e[2*NL-1 -: NL]));
        check("out_zero", 64'(out_zero_mask), 64'(e[NL-1:0]));
      end
      out_cnt++;
    end
  end

  // ---------------- driver ----------------
  bit rand_bp = 1'b0;

  task automatic send(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input bit push, output int t_acc);
    int n;
    n = 0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 200) check("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    t_acc = cyc;
    in_valid = 1'b0;
    if (push) exp_q.push_back(ref_model(op, a, b));
  endtask

  task automatic wait_out_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(tag, 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t1, t2, n, a0, o0;
    logic [VW-1:0] ra, rb;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu", 64'({alu_op, alu_a, alu_b}), 64'd0);
    check("rst_result", 64'({out_result, out_neg_mask, out_zero_mask}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD with latency check
    send(3'(ADD), 32'h04030201, 32'h03030303, 1'b1, t1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_out_valid("t1_timeout", n);
    check("t1_latency", 64'(n), 64'd4);
    check("t1_result", 64'(out_result), 64'h07060504);
    @(negedge clk);

    // 2: SUB with zero/neg masks
    send(3'(SUB), 32'h03050100, 32'h03020300, 1'b1, t1);
    wait_out_valid("t2_timeout", n);
    check("t2_result", 64'(out_result), 64'h0003FE00);
    check("t2_zero", 64'(out_zero_mask), 64'b1001);
    check("t2_neg", 64'(out_neg_mask), 64'b0010);
    @(negedge clk);

    // 3: MUL then SHL back-to-back
    o0 = out_cnt;
    send(3'(MUL), 32'h03030303, 32'h02020202, 1'b1, t1);
    check("t3_in_ready_busy", 64'(in_ready), 64'd0);
    send(3'(SHL), 32'h03030303, 32'h02020202, 1'b1, t2);
    check("t3_spacing", 64'(t2 - t1), 64'(NL + 2));
    check("t3_first_done", 64'(out_cnt - o0), 64'd1);
    wait_out_valid("t3_timeout", n);
    check("t3_result2", 64'(out_result), 64'h0C0C0C0C);
    @(negedge clk);

    // 4: backpressure hold
    out_ready = 1'b0;
    send(3'(XOR), 32'h03030303, 32'h02020202, 1'b1, t1);
    wait_out_valid("t4_timeout", n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_result", 64'(out_result), 64'h01010101);
      check("t4_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_idle_busy", 64'(busy), 64'd0);
    check("t4_idle_in_ready", 64'(in_ready), 64'd1);
    check("t4_out_valid_low", 64'(out_valid), 64'd0);
    check("t4_result_held", 64'(out_result), 64'h01010101);

    // 5: reset during lane 2 of INC
    send(3'(INC), 32'h04040404, 32'h00000000, 1'b0, t1);
    @(negedge clk);
    @(negedge clk);
    check("t5_lane2_op", 64'(alu_op), 64'd7);
    check("t5_lane2_res", 64'(alu_result), 64'd5);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3'(ADD), 32'h80FF0110, 32'h80011020, 1'b1, t1);
    wait_out_valid("t5_timeout", n);
    check("t5_add_result", 64'(out_result), 64'h00001130);
    @(negedge clk);

    // 6: SHR with in_valid held through busy
    a0 = acc_cnt;
    in_op = 3'(SHR); in_a = 32'h03030303; in_b = 32'h01010101; in_valid = 1'b1;
    exp_q.push_back(ref_model(3'(SHR), 32'h03030303, 32'h01010101));
    @(negedge clk);
    check("t6_in_ready_busy", 64'(in_ready), 64'd0);
    wait_out_valid("t6_timeout", n);
    in_valid = 1'b0;
    check("t6_alu_op_idle", 64'(alu_op), 64'd0);
    check("t6_result", 64'(out_result), 64'h01010101);
    @(negedge clk);
    @(negedge clk);
    check("t6_accepts", 64'(acc_cnt - a0), 64'd1);

    // Random phase with random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 24; k++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 1) == 1) rb = rb & 32'h07070707;
      send(3'($urandom_range(0, 7)), ra, rb, 1'b1, t1);
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
